aes_mmio_initiator: RTL
=======================

AES_MMIO_INITIATOR -- requirements
Module: aes_mmio_initiator

Interface
REQ-001 SHALL have parameter AES_BASE, default 32'h0004_0000, meaning the base address of the coprocessor window.
REQ-002 SHALL have parameter CTRL_OFFSET, default 20'h40300, meaning the address of the control register (low 20 bits).
REQ-003 SHALL have parameter DATA_OFFSET, default 10'h000, meaning the first block word; KEY_OFFSET, default 10'h010, meaning the first key word.
REQ-004 SHALL have parameter RD_LATENCY, default 1, meaning the cycles from read address to valid bus_data_in; TIMEOUT, default 4096, meaning the maximum number of poll reads.
REQ-005 Port clk_in, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-006 Port rst_in, input, 1, asynchronous active-low reset.
REQ-007 Port req_valid_in / req_ready_out, input / output, 1 / 1, job handshake.
REQ-008 Port req_decrypt_in, input, 1, 0 = encrypt, 1 = decrypt.
REQ-009 Port req_key_valid_in, input, 1; 1 = load req_key_in, 0 = reuse the resident key.
REQ-010 Port req_data_in and req_key_in, input, 128 each, the block and the key.
REQ-011 Port resp_valid_out / resp_ready_in, output / input, 1 / 1, result handshake.
REQ-012 Port resp_data_out, output, 128, the result block; resp_error_out, output, 1, poll timeout.
REQ-013 Port bus_addr_out, output, 32, MMIO address driven into the coprocessor.
REQ-014 Port bus_data_out, output, 32, MMIO write data; bus_we_out, output, 4, byte write enables.
REQ-015 Port bus_data_in, input, 32, MMIO read data.

Function
REQ-016 Word i of any 128-bit value SHALL be bits [32i+31:32i], located at AES_BASE | (OFFSET + 4i), for i = 0..3 in ascending order.
REQ-017 FSM states SHALL be IDLE, WR_KEY, WR_DATA, START, POLL, RD_RES, CLEAR, RESP.
REQ-018 req_ready_out SHALL be 1 only in IDLE; a handshake SHALL latch all req_* fields and go to WR_KEY if req_key_valid_in=1, otherwise to WR_DATA.
REQ-019 WR_KEY and WR_DATA SHALL each issue four consecutive single-cycle writes with bus_we_out=4'hF, one word per cycle.
REQ-020 START SHALL write the control register for one cycle with data {29'b0, 1'b0, dec, ~dec}.
REQ-021 Each POLL/RD_RES read SHALL hold bus_addr_out stable with bus_we_out=0 and sample bus_data_in exactly RD_LATENCY cycles after issue.
REQ-022 A poll sample with bit2=1 and bits[1:0]=0 SHALL go to RD_RES; any other sample SHALL re-issue the poll.
REQ-023 RD_RES SHALL read the four result words from DATA_OFFSET into resp_data_out.
REQ-024 CLEAR SHALL write 32'h0 to the control register for one cycle, then go to RESP.
REQ-025 After TIMEOUT unsuccessful polls, the block SHALL set resp_error_out=1, leave resp_data_out unchanged, and go to CLEAR.
REQ-026 In RESP, resp_valid_out SHALL be 1 with data and error stable until resp_ready_in=1, then return to IDLE; no new request SHALL be accepted in that same cycle.
REQ-027 Outside write cycles, bus_we_out SHALL be 0; bus_addr_out and bus_data_out SHALL be registered outputs.
REQ-028 With RD_LATENCY=1 and an immediate done, the time from accept to resp_valid_out SHALL be 4+4+1+2+8+1+1 = 21 cycles with a key load, and 17 without.

Reset
REQ-029 When rst_in=0, the block SHALL asynchronously enter IDLE with all outputs 0 and req_ready_out=0 while in reset.
REQ-030 req_ready_out SHALL go to 1 on the first clock after rst_in rises.
REQ-031 A reset mid-job SHALL abort the job with no response and no further bus writes.

Structure
REQ-032 The state enum, the word-count constant (4), and the control bit positions (VALID=2, DEC=1, ENC=0) SHALL live in a shared package, aes_pkg.
REQ-033 One sub-module, mmio_read_port, SHALL implement the issue / RD_LATENCY wait / capture read sequencer, reused by POLL and RD_RES.

Verification
REQ-034 With a responder model and FIPS-197 key 000102..0f and plaintext 00112233445566778899aabbccddeeff, encrypt SHALL return 69c4e0d86a7b0430d8cdb78070b4c55a with error=0 in 21 cycles.
REQ-035 Decrypt with req_key_valid_in=0 on that ciphertext SHALL show no writes to KEY_OFFSET and SHALL return the plaintext.
REQ-036 With a responder that asserts done after 50 polls, exactly 50 poll reads SHALL be issued and the result SHALL be correct.
REQ-037 With a responder that never asserts done and TIMEOUT=8, there SHALL be 8 polls, then a CLEAR write of 0, then resp_valid=1 with error=1.
REQ-038 Holding resp_ready_in=0 for 10 cycles SHALL keep resp_valid_out and resp_data_out stable, and req_ready_out=0 throughout.
REQ-039 Asserting rst_in=0 during WR_DATA word 2 SHALL force bus_we_out=0 at once and give no response; a fresh job after reset SHALL complete correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES coprocessor MMIO initiator.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_KEY,
        WR_DATA,
        START,
        POLL,
        RD_RES,
        CLEAR,
        RESP
    } aes_state_e;

    localparam int unsigned NUM_WORDS      = 4;
    localparam int unsigned CTRL_VALID_BIT = 2;
    localparam int unsigned CTRL_DEC_BIT   = 1;
    localparam int unsigned CTRL_ENC_BIT   = 0;

    // Word idx of a 128-bit value, word 0 being the least significant.
    function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] idx);
        return v[{idx, 5'b00000} +: 32];
    endfunction

    // Control word that kicks off a job; the VALID bit is owned by the coprocessor.
    function automatic logic [31:0] ctrl_word(input logic dec);
        logic [31:0] w;
        w               = '0;
        w[CTRL_DEC_BIT] = dec;
        w[CTRL_ENC_BIT] = ~dec;
        return w;
    endfunction

endpackage

// File: rtl/mmio_read_port.sv
// Read sequencer: the cycle the address is on the bus is the issue cycle,
// and the read data is flagged valid exactly RD_LATENCY cycles later.
module mmio_read_port
    import aes_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        issue_in,
    input  logic [31:0] bus_data_in,
    output logic        busy_out,
    output logic        valid_out,
    output logic [31:0] data_out
);

    localparam int unsigned CW = $clog2(RD_LATENCY + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Load the latency on issue, then count down to the capture cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (issue_in) begin
            cnt_d = CW'(RD_LATENCY);
        end
    end

    // Latency counter register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_out  = (cnt_q != '0);
    assign valid_out = (cnt_q == CW'(1));
    assign data_out  = bus_data_in;

endmodule

// File: rtl/aes_mmio_initiator.sv
// Drives one AES job through the coprocessor's MMIO window: key/block
// writes, start, status polling with timeout, result readback, clear.
module aes_mmio_initiator
    import aes_pkg::*;
#(
    parameter logic [31:0] AES_BASE    = 32'h0004_0000,
    parameter logic [19:0] CTRL_OFFSET = 20'h40300,
    parameter logic [9:0]  DATA_OFFSET = 10'h000,
    parameter logic [9:0]  KEY_OFFSET  = 10'h010,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         req_valid_in,
    output logic         req_ready_out,
    input  logic         req_decrypt_in,
    input  logic         req_key_valid_in,
    input  logic [127:0] req_data_in,
    input  logic [127:0] req_key_in,
    output logic         resp_valid_out,
    input  logic         resp_ready_in,
    output logic [127:0] resp_data_out,
    output logic         resp_error_out,
    output logic [31:0]  bus_addr_out,
    output logic [31:0]  bus_data_out,
    output logic [3:0]   bus_we_out,
    input  logic [31:0]  bus_data_in
);

    localparam int unsigned PCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] CTRL_ADDR = AES_BASE | {12'h000, CTRL_OFFSET};

    function automatic logic [31:0] word_addr(input logic [9:0] off, input logic [1:0] idx);
        return AES_BASE | ({22'h0, off} + {28'h0, idx, 2'b00});
    endfunction

    aes_state_e     state_q, state_d;
    logic [1:0]     word_q, word_d;
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic           dec_q, dec_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   resp_data_q, resp_data_d;
    logic           resp_err_q, resp_err_d;
    logic           resp_valid_q, resp_valid_d;
    logic           ready_q, ready_d;
    logic [31:0]    bus_addr_q, bus_addr_d;
    logic [31:0]    bus_data_q, bus_data_d;
    logic [3:0]     bus_we_q, bus_we_d;

    logic           rd_issue;
    logic           rd_busy;
    logic           rd_valid;
    logic [31:0]    rd_data;

    mmio_read_port #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .issue_in   (rd_issue),
        .bus_data_in(bus_data_in),
        .busy_out   (rd_busy),
        .valid_out  (rd_valid),
        .data_out   (rd_data)
    );

    // Next state and next registered outputs. The bus registers are loaded
    // from the next state so each bus cycle lines up with its FSM state.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        poll_cnt_d   = poll_cnt_q;
        dec_d        = dec_q;
        key_d        = key_q;
        data_d       = data_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        rd_issue     = 1'b0;
        bus_addr_d   = '0;
        bus_data_d   = '0;
        bus_we_d     = '0;

        case (state_q)
            IDLE: begin
                if (req_valid_in && ready_q) begin
                    dec_d      = req_decrypt_in;
                    key_d      = req_key_in;
                    data_d     = req_data_in;
                    resp_err_d = 1'b0;
                    word_d     = '0;
                    state_d    = req_key_valid_in ? WR_KEY : WR_DATA;
                end
            end
            WR_KEY: begin
                word_d = word_q + 1'b1;
                if (word_q == 2'(NUM_WORDS - 1)) state_d = WR_DATA;
            end
            WR_DATA: begin
                word_d = word_q + 1'b1;
                if (word_q == 2'(NUM_WORDS - 1)) state_d = START;
            end
            START: begin
                poll_cnt_d = '0;
                state_d    = POLL;
            end
            POLL: begin
                rd_issue = !rd_busy;
                if (rd_valid) begin
                    if (rd_data[CTRL_VALID_BIT] && !rd_data[CTRL_DEC_BIT] && !rd_data[CTRL_ENC_BIT]) begin
                        word_d  = '0;
                        state_d = RD_RES;
                    end else if (poll_cnt_q == PCW'(TIMEOUT - 1)) begin
                        resp_err_d = 1'b1;
                        state_d    = CLEAR;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                    end
                end
            end
            RD_RES: begin
                rd_issue = !rd_busy;
                if (rd_valid) begin
                    resp_data_d[{word_q, 5'b00000} +: 32] = rd_data;
                    word_d = word_q + 1'b1;
                    if (word_q == 2'(NUM_WORDS - 1)) state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready_in) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            WR_KEY: begin
                bus_addr_d = word_addr(KEY_OFFSET, word_d);
                bus_data_d = word_sel(key_d, word_d);
                bus_we_d   = '1;
            end
            WR_DATA: begin
                bus_addr_d = word_addr(DATA_OFFSET, word_d);
                bus_data_d = word_sel(data_d, word_d);
                bus_we_d   = '1;
            end
            START: begin
                bus_addr_d = CTRL_ADDR;
                bus_data_d = ctrl_word(dec_d);
                bus_we_d   = '1;
            end
            POLL: begin
                bus_addr_d = CTRL_ADDR;
            end
            RD_RES: begin
                bus_addr_d = word_addr(DATA_OFFSET, word_d);
            end
            CLEAR: begin
                bus_addr_d = CTRL_ADDR;
                bus_we_d   = '1;
            end
            default: begin
            end
        endcase

        ready_d      = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    // State and output registers; reset aborts any job in flight.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            word_q       <= '0;
            poll_cnt_q   <= '0;
            dec_q        <= 1'b0;
            key_q        <= '0;
            data_q       <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            bus_we_q     <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            poll_cnt_q   <= poll_cnt_d;
            dec_q        <= dec_d;
            key_q        <= key_d;
            data_q       <= data_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
            ready_q      <= ready_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            bus_we_q     <= bus_we_d;
        end
    end

    assign req_ready_out  = ready_q;
    assign resp_valid_out = resp_valid_q;
    assign resp_data_out  = resp_data_q;
    assign resp_error_out = resp_err_q;
    assign bus_addr_out   = bus_addr_q;
    assign bus_data_out   = bus_data_q;
    assign bus_we_out     = bus_we_q;

endmodule
